// File: rtl/ysyx_23060191_seq_ctrl_pkg.sv
// Shared defines for the multi-cycle sequencing controller: datapath width,
// default bus timeout, FSM state encodings and the flags latched in EX.
package ysyx_23060191_seq_ctrl_pkg;

    localparam int unsigned CPU_WIDTH       = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned DEFAULT_CNT_W   = 32;
    localparam int unsigned STATE_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_IF_REQ   = 3'd1,
        S_IF_WAIT  = 3'd2,
        S_EX       = 3'd3,
        S_MEM_REQ  = 3'd4,
        S_MEM_WAIT = 3'd5,
        S_WB       = 3'd6,
        S_HALT     = 3'd7
    } state_e;

    // Decode information captured in EX and consumed in MEM_REQ / WB.
    typedef struct packed {
        logic store;
        logic rd_wen;
    } ex_flags_t;

    // Width of the wait counter: it must hold values up to timeout-1.
    function automatic int unsigned wait_width(input int unsigned timeout);
        return (timeout < 3) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/ysyx_23060191_seq_ctrl_if.sv
// Handshake/control bundle between the sequencer and the core.
//   master : sequencer side (consumes bus handshakes and decode flags,
//            drives requests, write enables, halt, bus error, instret)
//   slave  : core / memory side
interface ysyx_23060191_seq_ctrl_if
    import ysyx_23060191_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
);
    logic             i_ifu_ready;
    logic             i_ifu_rvalid;
    logic             i_load_en;
    logic             i_store_en;
    logic             i_rd_wen;
    logic             i_ebreak_en;
    logic             i_lsu_ready;
    logic             i_lsu_rvalid;

    logic             o_ifu_req;
    logic             o_inst_wen;
    logic             o_lsu_req;
    logic             o_lsu_wen;
    logic             o_rf_wen;
    logic             o_pc_wen;
    logic             o_halt;
    logic             o_bus_err;
    logic [CNT_W-1:0] o_instret;

    modport master (
        input  i_ifu_ready, i_ifu_rvalid, i_load_en, i_store_en,
               i_rd_wen, i_ebreak_en, i_lsu_ready, i_lsu_rvalid,
        output o_ifu_req, o_inst_wen, o_lsu_req, o_lsu_wen,
               o_rf_wen, o_pc_wen, o_halt, o_bus_err, o_instret
    );

    modport slave (
        output i_ifu_ready, i_ifu_rvalid, i_load_en, i_store_en,
               i_rd_wen, i_ebreak_en, i_lsu_ready, i_lsu_rvalid,
        input  o_ifu_req, o_inst_wen, o_lsu_req, o_lsu_wen,
               o_rf_wen, o_pc_wen, o_halt, o_bus_err, o_instret
    );

endinterface

// File: rtl/ysyx_23060191_seq_ctrl_reg_template.sv
// Generic enable register with asynchronous active-low reset to RESET_VAL.
//   clk, rstn : clock and async reset
//   wen       : load enable
//   din/dout  : WIDTH-bit data in / registered data out
module ysyx_23060191_seq_ctrl_reg_template #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_23060191_seq_ctrl.sv
// Multi-cycle instruction sequencer: walks fetch, execute, memory and
// write-back phases, watches bus responses with a timeout, counts retired
// instructions and halts on ebreak or bus error.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : handshake/control bundle (master side); o_pc_wen is the
//               write enable of the PC register
module ysyx_23060191_seq_ctrl
    import ysyx_23060191_seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    ysyx_23060191_seq_ctrl_if.master bus
);

    localparam int unsigned WAIT_W = wait_width(TIMEOUT);

    logic [STATE_W-1:0] state_raw;
    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   instret;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_cnt_nxt;
    ex_flags_t          flags;
    logic               in_wait;
    logic               resp;
    logic               timeout_hit;

    logic ifu_req, inst_wen, lsu_req, lsu_wen, rf_wen, pc_wen, halt, bus_err;

    // State register.
    ysyx_23060191_seq_ctrl_reg_template #(
        .WIDTH     (STATE_W),
        .RESET_VAL (STATE_W'(S_IDLE))
    ) u_state (
        .clk  (clk),
        .rstn (rstn),
        .wen  (1'b1),
        .din  (STATE_W'(state_nxt)),
        .dout (state_raw)
    );

    assign state = state_e'(state_raw);

    // Retired-instruction counter: one increment per WB cycle, wraps naturally.
    ysyx_23060191_seq_ctrl_reg_template #(
        .WIDTH     (CNT_W),
        .RESET_VAL ('0)
    ) u_instret (
        .clk  (clk),
        .rstn (rstn),
        .wen  (state == S_WB),
        .din  (instret + CNT_W'(1)),
        .dout (instret)
    );

    // Response tracking for the two wait states.
    always_comb begin
        in_wait     = (state == S_IF_WAIT) || (state == S_MEM_WAIT);
        resp        = (state == S_IF_WAIT) ? bus.i_ifu_rvalid : bus.i_lsu_rvalid;
        timeout_hit = in_wait && !resp && (wait_cnt == WAIT_W'(TIMEOUT - 1));
        // Held at zero outside the wait states, so every entry starts from 0.
        wait_cnt_nxt = (in_wait && !resp && !timeout_hit) ? wait_cnt + WAIT_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Decode flags captured in EX for use in MEM_REQ and WB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flags <= '0;
        end else if (state == S_EX) begin
            flags <= '{store: bus.i_store_en, rd_wen: bus.i_rd_wen};
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        ifu_req   = 1'b0;
        inst_wen  = 1'b0;
        lsu_req   = 1'b0;
        lsu_wen   = 1'b0;
        rf_wen    = 1'b0;
        pc_wen    = 1'b0;
        halt      = 1'b0;
        bus_err   = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_IF_REQ;
            end
            S_IF_REQ: begin
                ifu_req = 1'b1;
                if (bus.i_ifu_ready) begin
                    state_nxt = S_IF_WAIT;
                end
            end
            S_IF_WAIT: begin
                // A response in the timeout cycle still wins.
                if (bus.i_ifu_rvalid) begin
                    inst_wen  = 1'b1;
                    state_nxt = S_EX;
                end else if (timeout_hit) begin
                    bus_err   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_EX: begin
                if (bus.i_ebreak_en) begin
                    state_nxt = S_HALT;
                end else if (bus.i_load_en || bus.i_store_en) begin
                    state_nxt = S_MEM_REQ;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM_REQ: begin
                lsu_req = 1'b1;
                lsu_wen = flags.store;
                if (bus.i_lsu_ready) begin
                    state_nxt = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (bus.i_lsu_rvalid) begin
                    state_nxt = S_WB;
                end else if (timeout_hit) begin
                    bus_err   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                pc_wen    = 1'b1;
                rf_wen    = flags.rd_wen && !flags.store;
                state_nxt = S_IF_REQ;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_ifu_req  = ifu_req;
    assign bus.o_inst_wen = inst_wen;
    assign bus.o_lsu_req  = lsu_req;
    assign bus.o_lsu_wen  = lsu_wen;
    assign bus.o_rf_wen   = rf_wen;
    assign bus.o_pc_wen   = pc_wen;
    assign bus.o_halt     = halt;
    assign bus.o_bus_err  = bus_err;
    assign bus.o_instret  = instret;

endmodule

// File: doc/ysyx_23060191_seq_ctrl.md
YSYX_23060191_SEQ_CTRL -- requirements
Module: ysyx_23060191_seq_ctrl

Interface
REQ-001 SHALL take parameter TIMEOUT, default 16, meaning the maximum wait cycles for a bus response before error.
REQ-002 SHALL take parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_ifu_ready, input, 1 bit: the instruction memory accepts the fetch request.
REQ-006 SHALL have port i_ifu_rvalid, input, 1 bit: instruction data valid.
REQ-007 SHALL have port i_load_en, input, 1 bit: the decoded instruction is a load; sampled in EX.
REQ-008 SHALL have port i_store_en, input, 1 bit: the decoded instruction is a store; sampled in EX.
REQ-009 SHALL have port i_rd_wen, input, 1 bit: the decoded instruction writes rd.
REQ-010 SHALL have port i_ebreak_en, input, 1 bit: the decoded instruction is ebreak.
REQ-011 SHALL have port i_lsu_ready, input, 1 bit: the data memory accepts the request.
REQ-012 SHALL have port i_lsu_rvalid, input, 1 bit: load data valid or store acknowledge.
REQ-013 SHALL have outputs o_ifu_req, o_inst_wen, o_lsu_req, o_lsu_wen, o_rf_wen, o_pc_wen, o_halt and o_bus_err, each 1 bit.
REQ-014 SHALL have output o_instret, CNT_W bits: the count of retired instructions.

Function
REQ-015 States SHALL be IDLE, IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB and HALT.
REQ-016 IDLE SHALL go to IF_REQ unconditionally after one cycle.
REQ-017 In IF_REQ, o_ifu_req SHALL be 1; the FSM SHALL go to IF_WAIT on i_ifu_ready and otherwise stay.
REQ-018 In IF_WAIT with i_ifu_rvalid=1, o_inst_wen SHALL be 1 combinationally in the same cycle and the FSM SHALL go to EX.
REQ-019 EX SHALL last exactly one cycle.
REQ-020 From EX the next state SHALL be chosen by priority: i_ebreak_en goes to HALT; i_load_en or i_store_en goes to MEM_REQ; otherwise WB.
REQ-021 In MEM_REQ, o_lsu_req SHALL be 1 and o_lsu_wen SHALL equal the store flag latched in EX; the FSM SHALL go to MEM_WAIT on i_lsu_ready.
REQ-022 In MEM_WAIT with i_lsu_rvalid=1, the FSM SHALL go to WB.
REQ-023 WB SHALL last one cycle with o_pc_wen=1 and o_rf_wen equal to the rd_wen latched in EX, then go to IF_REQ.
REQ-024 o_rf_wen SHALL be forced to 0 in WB for a store.
REQ-025 o_instret SHALL increment by 1 at every WB cycle and wrap modulo 2^CNT_W.
REQ-026 A wait counter SHALL clear on entry to IF_WAIT or MEM_WAIT and increment each cycle spent there without a valid response.
REQ-027 When the wait counter reaches TIMEOUT-1 without a valid response, o_bus_err SHALL be 1 for that cycle and the FSM SHALL go to HALT.
REQ-028 If a valid response arrives in the same cycle the counter reaches TIMEOUT-1, the response SHALL win and no error is raised.
REQ-029 HALT SHALL be absorbing until reset, with o_halt=1 and all request and write-enable outputs 0.
REQ-030 The ebreak path SHALL NOT assert o_pc_wen and SHALL NOT increment o_instret.
REQ-031 All outputs except o_halt and o_instret SHALL be pure decodes of state and inputs, with no extra latency.

Reset
REQ-032 On rstn=0 the block SHALL asynchronously enter IDLE, clear o_instret, the wait counter and the latched flags, and drive every 1-bit output to 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; no partial WB SHALL occur after release.

Structure
REQ-034 The state encodings and the default TIMEOUT SHALL live in the shared defines package alongside CPU_WIDTH.
REQ-035 The state register and o_instret SHALL use the existing RegTemplate sub-module; no other sub-module SHALL be used.
REQ-036 o_pc_wen SHALL drive the wen input of the PC register, replacing its constant enable.

Verification
REQ-037 ALU instruction with ready and rvalid high each cycle -> IF_REQ, IF_WAIT, EX, WB; o_pc_wen pulses once per 4 cycles; o_instret=1 after the first WB.
REQ-038 Load with i_lsu_ready delayed 2 cycles and rvalid 3 cycles later -> o_lsu_req held 3 cycles; o_rf_wen=1 in WB; o_lsu_wen=0.
REQ-039 Store with i_rd_wen=1 -> o_lsu_wen=1 in MEM_REQ; o_rf_wen=0 in WB.
REQ-040 i_ifu_rvalid never asserted, TIMEOUT=16 -> o_bus_err pulses 15 cycles after entering IF_WAIT; o_halt stays 1 afterwards.
REQ-041 i_ebreak_en=1 in EX -> HALT next cycle; o_pc_wen never asserted; o_instret unchanged.
REQ-042 rstn pulsed low during MEM_WAIT -> IDLE immediately, o_instret=0, fetch restarts 2 cycles after release.
